// File: rtl/chunk_head_masked.sv
// chunk_head_masked: per accepted (bofs,aofs) tuple, walks the enabled config ids
// in [i_beg, i_end) and emits one memory offset vector per id, one per cycle when
// downstream accepts back-to-back.
// Optional feature: define CHUNK_HEAD_SKIP_EN to add i_skip_cfg / i_from_side / o_skip.
//
// Handshake (both sides): a transfer happens on a clock edge where rdy && ack.
// rdy never drops without ack. The producer holds data stable while rdy is high.
// i_abofs_ack is combinational and pulses in the cycle the tuple is finished.
// Output data o_mofs/o_id/o_last is registered and holds while o_mofs_rdy && !o_mofs_ack.
module chunk_head_masked #(
    parameter int BW      = 16,
    parameter int VDIM    = 2,
    parameter int DIM     = 4,
    parameter int N_ICFG  = 4,
    parameter int SF_BW   = 4,
    parameter int SS_BW   = 3,
    parameter int ICFG_BW = $clog2(N_ICFG + 1),
    parameter int DIM_BW  = $clog2(DIM)
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_abofs_rdy,
    output logic                                        i_abofs_ack,
    input  logic [VDIM-1:0][BW-1:0]                     i_bofs,
    input  logic [VDIM-1:0][BW-1:0]                     i_aofs,
    input  logic [ICFG_BW-1:0]                          i_beg,
    input  logic [ICFG_BW-1:0]                          i_end,
    input  logic [N_ICFG-1:0]                           i_id_mask,
    input  logic [N_ICFG-1:0][DIM-1:0][BW-1:0]          i_global_mofs,
    input  logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0]     i_bshufs,
    input  logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0]     i_ashufs,
    input  logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]      i_bstr_frac,
    input  logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]      i_astr_frac,
    input  logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]      i_bstr_shamt,
    input  logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]      i_astr_shamt,
`ifdef CHUNK_HEAD_SKIP_EN
    input  logic [N_ICFG-1:0]                           i_skip_cfg,
    input  logic                                        i_from_side,
    output logic                                        o_skip,
`endif
    output logic                                        o_mofs_rdy,
    input  logic                                        o_mofs_ack,
    output logic [DIM-1:0][BW-1:0]                      o_mofs,
    output logic [ICFG_BW-1:0]                          o_id,
    output logic                                        o_last,
    output logic                                        o_dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ICFG_BW-1:0]      id_q, id_d;
    logic                    last_q, last_d;
    logic [DIM-1:0][BW-1:0]  mofs_q, mofs_d;
`ifdef CHUNK_HEAD_SKIP_EN
    logic                    skip_q, skip_d;
`endif

    logic                    load;
    logic [ICFG_BW-1:0]      load_id;
    logic [ICFG_BW:0]        first_hit;   // {found, id}
    logic [ICFG_BW:0]        after_hit;
    logic [ICFG_BW:0]        follow_hit;
    logic [DIM-1:0][BW-1:0]  calc_mofs;

    // Smallest enabled id q with p <= q < end_id; MSB of the result is the found flag.
    // Scanning from the top down lets the lowest match overwrite the others.
    function automatic logic [ICFG_BW:0] find_next(
        input logic [ICFG_BW-1:0] p,
        input logic [ICFG_BW-1:0] end_id,
        input logic [N_ICFG-1:0]  mask
    );
        logic [ICFG_BW:0]   res;
        logic [ICFG_BW-1:0] qv;
        res = '0;
        for (int q = N_ICFG - 1; q >= 0; q--) begin
            qv = ICFG_BW'(q);
            if (qv >= p && qv < end_id && mask[q]) begin
                res = {1'b1, qv};
            end
        end
        return res;
    endfunction

    assign first_hit  = find_next(i_beg, i_end, i_id_mask);
    assign after_hit  = find_next(id_q + ICFG_BW'(1), i_end, i_id_mask);
    assign follow_hit = find_next(load_id + ICFG_BW'(1), i_end, i_id_mask);

    // Handshake decision: next state, tuple ack, and which id (if any) to load.
    always_comb begin
        state_d     = state_q;
        i_abofs_ack = 1'b0;
        load        = 1'b0;
        load_id     = '0;
        case (state_q)
            IDLE: begin
                if (i_abofs_rdy) begin
                    if (!first_hit[ICFG_BW]) begin
                        // Nothing enabled in range: consume the tuple without output.
                        i_abofs_ack = 1'b1;
                    end else begin
                        load    = 1'b1;
                        load_id = first_hit[ICFG_BW-1:0];
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (o_mofs_ack) begin
                    if (last_q) begin
                        i_abofs_ack = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        load    = 1'b1;
                        load_id = after_hit[ICFG_BW-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Offset arithmetic for load_id: base plus shuffled, strided block/alu terms, all mod 2^BW.
    always_comb begin
        logic [DIM-1:0][BW-1:0]           gm;
        logic [VDIM-1:0][DIM_BW-1:0]      bshuf, ashuf;
        logic [VDIM-1:0][SF_BW-1:0]       bfrac, afrac;
        logic [VDIM-1:0][SS_BW-1:0]       bsh, ash;
        logic [BW-1:0]                    term;
        gm    = '0;
        bshuf = '0;
        ashuf = '0;
        bfrac = '0;
        afrac = '0;
        bsh   = '0;
        ash   = '0;
        term  = '0;
        // Config select as a compare mux so the id width need not match the array depth.
        for (int k = 0; k < N_ICFG; k++) begin
            if (load_id == ICFG_BW'(k)) begin
                gm    = i_global_mofs[k];
                bshuf = i_bshufs[k];
                ashuf = i_ashufs[k];
                bfrac = i_bstr_frac[k];
                afrac = i_astr_frac[k];
                bsh   = i_bstr_shamt[k];
                ash   = i_astr_shamt[k];
            end
        end
        calc_mofs = gm;
        // A shuffle value with no matching dim (>= DIM) simply never matches and adds nothing.
        for (int d = 0; d < DIM; d++) begin
            for (int v = 0; v < VDIM; v++) begin
                if (bshuf[v] == DIM_BW'(d)) begin
                    term         = i_bofs[v] * BW'(bfrac[v]);
                    term         = term << bsh[v];
                    calc_mofs[d] = calc_mofs[d] + term;
                end
                if (ashuf[v] == DIM_BW'(d)) begin
                    term         = i_aofs[v] * BW'(afrac[v]);
                    term         = term << ash[v];
                    calc_mofs[d] = calc_mofs[d] + term;
                end
            end
        end
    end

    // Output register next values: load a new vector or hold.
    always_comb begin
        id_d   = id_q;
        last_d = last_q;
        mofs_d = mofs_q;
`ifdef CHUNK_HEAD_SKIP_EN
        skip_d = skip_q;
`endif
        if (load) begin
            id_d   = load_id;
            last_d = !follow_hit[ICFG_BW];
            mofs_d = calc_mofs;
`ifdef CHUNK_HEAD_SKIP_EN
            skip_d = 1'b0;
            for (int k = 0; k < N_ICFG; k++) begin
                if (load_id == ICFG_BW'(k)) begin
                    skip_d = i_skip_cfg[k] && i_from_side;
                end
            end
`endif
        end
    end

    // State and output registers; async reset drops any partial tuple.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            last_q  <= 1'b0;
            mofs_q  <= '0;
`ifdef CHUNK_HEAD_SKIP_EN
            skip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            mofs_q  <= mofs_d;
`ifdef CHUNK_HEAD_SKIP_EN
            skip_q  <= skip_d;
`endif
        end
    end

    assign o_mofs_rdy  = (state_q == RUN);
    assign o_mofs      = mofs_q;
    assign o_id        = id_q;
    assign o_last      = last_q;
    assign o_dbg_state = state_q;
`ifdef CHUNK_HEAD_SKIP_EN
    assign o_skip      = skip_q;
`endif

endmodule

// File: tb/tb_chunk_head_masked.sv
// Bench for chunk_head_masked: directed tuple tables, arithmetic vectors,
// random downstream stalls, reset mid-tuple, and (with CHUNK_HEAD_SKIP_EN) o_skip.
module tb_chunk_head_masked;

    localparam int BW = 16, VDIM = 2, DIM = 4, N_ICFG = 4;
    localparam int SF_BW = 4, SS_BW = 3, ICFG_BW = 3, DIM_BW = 2;
    localparam int W = 1 + ICFG_BW + 1 + DIM * BW;   // {skip, id, last, mofs}

    logic                                    i_clk, i_rst;
    logic                                    i_abofs_rdy, i_abofs_ack;
    logic [VDIM-1:0][BW-1:0]                 i_bofs, i_aofs;
    logic [ICFG_BW-1:0]                      i_beg, i_end;
    logic [N_ICFG-1:0]                       i_id_mask;
    logic [N_ICFG-1:0][DIM-1:0][BW-1:0]      i_global_mofs;
    logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0] i_bshufs, i_ashufs;
    logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]  i_bstr_frac, i_astr_frac;
    logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]  i_bstr_shamt, i_astr_shamt;
    logic                                    o_mofs_rdy, o_mofs_ack;
    logic [DIM-1:0][BW-1:0]                  o_mofs;
    logic [ICFG_BW-1:0]                      o_id;
    logic                                    o_last, o_dbg_state;
    logic [N_ICFG-1:0]                       skip_cfg_v;
    logic                                    from_side_v;
    logic                                    act_skip;
`ifdef CHUNK_HEAD_SKIP_EN
    logic                                    o_skip;
    assign act_skip = o_skip;
`else
    assign act_skip = 1'b0;
`endif

    chunk_head_masked dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_abofs_rdy(i_abofs_rdy), .i_abofs_ack(i_abofs_ack),
        .i_bofs(i_bofs), .i_aofs(i_aofs),
        .i_beg(i_beg), .i_end(i_end), .i_id_mask(i_id_mask),
        .i_global_mofs(i_global_mofs),
        .i_bshufs(i_bshufs), .i_ashufs(i_ashufs),
        .i_bstr_frac(i_bstr_frac), .i_astr_frac(i_astr_frac),
        .i_bstr_shamt(i_bstr_shamt), .i_astr_shamt(i_astr_shamt),
`ifdef CHUNK_HEAD_SKIP_EN
        .i_skip_cfg(skip_cfg_v), .i_from_side(from_side_v), .o_skip(o_skip),
`endif
        .o_mofs_rdy(o_mofs_rdy), .o_mofs_ack(o_mofs_ack),
        .o_mofs(o_mofs), .o_id(o_id), .o_last(o_last),
        .o_dbg_state(o_dbg_state)
    );

    // Clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_skip(input logic [ICFG_BW-1:0] id);
`ifdef CHUNK_HEAD_SKIP_EN
        return skip_cfg_v[id[1:0]] && from_side_v;
`else
        return 1'b0;
`endif
    endfunction

    // Sequence config: offsets all zero, so o_mofs[d] = 16'h100*id + d.
    function automatic logic [DIM*BW-1:0] gm_of(input logic [ICFG_BW-1:0] id);
        logic [DIM-1:0][BW-1:0] r;
        for (int d = 0; d < DIM; d++) r[d] = BW'(16'h100 * id + d);
        return r;
    endfunction

    task automatic push_exp(input logic [ICFG_BW-1:0] id, input logic last);
        exp_q.push_back({exp_skip(id), id, last, gm_of(id)});
    endtask

    task automatic config_seq();
        for (int k = 0; k < N_ICFG; k++)
            for (int d = 0; d < DIM; d++) i_global_mofs[k][d] = BW'(16'h100 * k + d);
        i_bofs = '0; i_aofs = '0;
        i_bshufs = '0; i_ashufs = '0;
        i_bstr_frac = '0; i_astr_frac = '0;
        i_bstr_shamt = '0; i_astr_shamt = '0;
    endtask

    // Driver: offer one tuple, accept outputs, check each transfer and the tuple ack timing.
    task automatic run_tuple(input string name, input logic [2:0] beg, input logic [2:0] end_v,
                             input logic [3:0] mask, input bit rand_ack);
        bit done, stall, want_ack, none_expected;
        logic [W-1:0] held, e, act;
        done = 0; stall = 0; held = '0;
        none_expected = (exp_q.size() == 0);
        @(negedge i_clk);
        i_beg = beg; i_end = end_v; i_id_mask = mask; i_abofs_rdy = 1'b1;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc > 0) @(negedge i_clk);
            o_mofs_ack = o_mofs_rdy ? (rand_ack ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            #1;
            act = {act_skip, o_id, o_last, o_mofs};
            if (stall) chk({name, "_hold"}, {o_mofs_rdy, act}, {1'b1, held});
            stall = o_mofs_rdy && !o_mofs_ack;
            held = act;
            want_ack = none_expected;
            if (o_mofs_rdy && o_mofs_ack) begin
                if (exp_q.size() == 0) begin
                    chk({name, "_extra_out"}, act, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk({name, "_out"}, act, e);
                    want_ack = e[DIM*BW];
                end
            end
            chk({name, "_abofs_ack"}, W'(i_abofs_ack), W'(want_ack));
            if (i_abofs_ack) begin
                done = 1;
                chk({name, "_left"}, W'(exp_q.size()), '0);
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no i_abofs_ack, got 0 expected 1", name);
        end
        exp_q.delete();
        @(negedge i_clk);
        i_abofs_rdy = 1'b0; o_mofs_ack = 1'b0;
        #1 chk({name, "_idle_after"}, W'(o_mofs_rdy), '0);
    endtask

    // Directed tuple table
    typedef struct packed {
        logic [2:0]       beg;
        logic [2:0]       end_v;
        logic [3:0]       mask;
        logic [2:0]       n;
        logic [3:0][2:0]  ids;   // ids[0] emitted first
    } seq_t;

    function automatic seq_t mk_seq(input logic [2:0] b, input logic [2:0] e, input logic [3:0] m,
                                    input logic [2:0] n, input logic [2:0] i0, input logic [2:0] i1,
                                    input logic [2:0] i2, input logic [2:0] i3);
        seq_t s;
        s.beg = b; s.end_v = e; s.mask = m; s.n = n;
        s.ids[0] = i0; s.ids[1] = i1; s.ids[2] = i2; s.ids[3] = i3;
        return s;
    endfunction

    // Arithmetic table (each vector placed in config slot id, others filled with noise)
    typedef struct packed {
        logic [1:0]                     id;
        logic [DIM-1:0][BW-1:0]         gm;
        logic [VDIM-1:0][BW-1:0]        bofs, aofs;
        logic [VDIM-1:0][SF_BW-1:0]     bfrac, afrac;
        logic [VDIM-1:0][SS_BW-1:0]     bsh, ash;
        logic [VDIM-1:0][DIM_BW-1:0]    bshuf, ashuf;
        logic [DIM-1:0][BW-1:0]         exp;
    } arith_t;

    task automatic config_arith(input arith_t v);
        for (int k = 0; k < N_ICFG; k++) begin
            for (int d = 0; d < DIM; d++) i_global_mofs[k][d] = 16'h5555;
            i_bstr_frac[k] = '1; i_astr_frac[k] = '1;
            i_bstr_shamt[k] = {3'd1, 3'd1}; i_astr_shamt[k] = {3'd1, 3'd1};
            i_bshufs[k] = '0; i_ashufs[k] = '0;
        end
        i_global_mofs[v.id] = v.gm;
        i_bofs = v.bofs; i_aofs = v.aofs;
        i_bstr_frac[v.id] = v.bfrac; i_astr_frac[v.id] = v.afrac;
        i_bstr_shamt[v.id] = v.bsh; i_astr_shamt[v.id] = v.ash;
        i_bshufs[v.id] = v.bshuf; i_ashufs[v.id] = v.ashuf;
    endtask

    seq_t   seq_tab[7];
    arith_t ar_tab[4];

    initial begin
        seq_tab[0] = mk_seq(3'd0, 3'd3, 4'b1111, 3'd3, 3'd0, 3'd1, 3'd2, 3'd0);
        seq_tab[1] = mk_seq(3'd0, 3'd4, 4'b1010, 3'd2, 3'd1, 3'd3, 3'd0, 3'd0);
        seq_tab[2] = mk_seq(3'd2, 3'd2, 4'b1111, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        seq_tab[3] = mk_seq(3'd0, 3'd4, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        seq_tab[4] = mk_seq(3'd1, 3'd4, 4'b0110, 3'd2, 3'd1, 3'd2, 3'd0, 3'd0);
        seq_tab[5] = mk_seq(3'd3, 3'd7, 4'b1111, 3'd1, 3'd3, 3'd0, 3'd0, 3'd0);
        seq_tab[6] = mk_seq(3'd3, 3'd1, 4'b1111, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);

        ar_tab[0] = '{id: 2'd0, gm: {16'd0, 16'd0, 16'd0, 16'd7},
                      bofs: {16'd5, 16'd3}, aofs: '0, bfrac: {4'd1, 4'd2}, afrac: '0,
                      bsh: {3'd0, 3'd1}, ash: '0, bshuf: {2'd0, 2'd0}, ashuf: '0,
                      exp: {16'd0, 16'd0, 16'd0, 16'd24}};
        ar_tab[1] = '{id: 2'd1, gm: {16'd400, 16'd300, 16'd200, 16'd100},
                      bofs: {16'd2, 16'd1}, aofs: {16'd20, 16'd10},
                      bfrac: {4'd4, 4'd3}, afrac: {4'd2, 4'd1},
                      bsh: {3'd1, 3'd2}, ash: {3'd3, 3'd0},
                      bshuf: {2'd3, 2'd1}, ashuf: {2'd3, 2'd2},
                      exp: {16'd736, 16'd310, 16'd212, 16'd100}};
        ar_tab[2] = '{id: 2'd2, gm: {16'd0, 16'd0, 16'd0, 16'd65530},
                      bofs: {16'd0, 16'hFFFF}, aofs: '0, bfrac: {4'd0, 4'd15}, afrac: '0,
                      bsh: {3'd0, 3'd7}, ash: '0, bshuf: {2'd1, 2'd0}, ashuf: '0,
                      exp: {16'd0, 16'd0, 16'd0, 16'd63610}};
        ar_tab[3] = '{id: 2'd3, gm: {16'd4, 16'd3, 16'd2, 16'd1},
                      bofs: {16'd4, 16'd4}, aofs: {16'd1, 16'd8},
                      bfrac: {4'd1, 4'd1}, afrac: {4'd15, 4'd1},
                      bsh: {3'd0, 3'd0}, ash: {3'd0, 3'd1},
                      bshuf: {2'd2, 2'd2}, ashuf: {2'd0, 2'd2},
                      exp: {16'd4, 16'd27, 16'd2, 16'd16}};

        i_rst = 1'b0; i_abofs_rdy = 1'b0; o_mofs_ack = 1'b0;
        i_beg = '0; i_end = '0; i_id_mask = '0;
        skip_cfg_v = '0; from_side_v = 1'b0;
        config_seq();

        // Reset state
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_rdy", W'(o_mofs_rdy), '0);
        chk("rst_mofs", W'(o_mofs), '0);
        chk("rst_id", W'(o_id), '0);
        chk("rst_last", W'(o_last), '0);
        chk("rst_ack", W'(i_abofs_ack), '0);
        chk("rst_state", W'(o_dbg_state), '0);
        @(negedge i_clk);
        i_rst = 1'b1;

        // Directed tuples, downstream always ready
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < int'(seq_tab[i].n); j++)
                push_exp(seq_tab[i].ids[j], j == int'(seq_tab[i].n) - 1);
            run_tuple($sformatf("seq%0d", i), seq_tab[i].beg, seq_tab[i].end_v, seq_tab[i].mask, 0);
        end

        // Random downstream stalls
        for (int r = 0; r < 4; r++) begin
            push_exp(3'd0, 0); push_exp(3'd1, 0); push_exp(3'd2, 0); push_exp(3'd3, 1);
            run_tuple("stall_full", 3'd0, 3'd4, 4'b1111, 1);
            push_exp(3'd1, 0); push_exp(3'd3, 1);
            run_tuple("stall_mask", 3'd0, 3'd4, 4'b1010, 1);
        end

        // Arithmetic vectors
        for (int i = 0; i < 4; i++) begin
            config_arith(ar_tab[i]);
            exp_q.push_back({exp_skip(3'(ar_tab[i].id)), 3'(ar_tab[i].id), 1'b1, ar_tab[i].exp});
            run_tuple($sformatf("arith%0d", i), 3'(ar_tab[i].id), 3'(ar_tab[i].id) + 3'd1, 4'b1111, 0);
        end

        // Reset in the middle of a tuple
        config_seq();
        @(negedge i_clk);
        i_beg = 3'd0; i_end = 3'd3; i_id_mask = 4'b1111; i_abofs_rdy = 1'b1; o_mofs_ack = 1'b0;
        repeat (2) @(negedge i_clk);
        #1 chk("midrst_run", W'(o_mofs_rdy), W'(1));
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("midrst_rdy", W'(o_mofs_rdy), '0);
        chk("midrst_regs", {act_skip, o_id, o_last, o_mofs}, '0);
        chk("midrst_ack", W'(i_abofs_ack), '0);
        i_abofs_rdy = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        push_exp(3'd1, 0); push_exp(3'd2, 1);
        run_tuple("after_rst", 3'd1, 3'd3, 4'b1111, 0);

`ifdef CHUNK_HEAD_SKIP_EN
        skip_cfg_v = 4'b0010; from_side_v = 1'b1;
        push_exp(3'd0, 0); push_exp(3'd1, 0); push_exp(3'd2, 1);
        run_tuple("skip_side", 3'd0, 3'd3, 4'b1111, 0);
        from_side_v = 1'b0;
        push_exp(3'd0, 0); push_exp(3'd1, 0); push_exp(3'd2, 1);
        run_tuple("skip_noside", 3'd0, 3'd3, 4'b1111, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
